cla_adder_pipe: RTL
===================

Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the multiplier datapath.
- Consumes the sum/carry vectors from the compression tree and produces the final product word.
- Built from generic GROUP_W-bit lookahead groups arranged in a multi-level P/G tree.
- Adds valid/ready flow control, subtract mode, carry-out and signed overflow.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUP_W, minimum GROUP_W.
- GROUP_W, 4, bits per lookahead group; fan-in of every tree node.
- PIPE, 1, number of registers between the P/G tree and the sum stage; legal values 0 or 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry in; used only when sub=0.
- sub  in  1  1: a-b; 0: a+b+c_in.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of MSB; for sub, 1 means no borrow.
- ovf  out  1  two's-complement overflow.

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits. Outputs while in reset: out_valid=0, sum=0, c_out=0, ovf=0. in_ready=0 while rst_n low.
- Accept: a beat is accepted when in_valid & in_ready at a clk edge.
- Stage 0 (input register): captures a, b'=sub?~b:b, and cin'=sub?1:c_in.
- Stage 1 (lookahead): bit p=a^b', g=a&b'. Group P/G and all carries are formed by a lookahead tree of cla_group_n nodes with depth ceil(log_GROUP_W(WIDTH)). No carry ripples across more than one group. Registered when PIPE=1.
- Stage 2 (sum/output register): sum=p^carry. c_out=carry[WIDTH]. ovf=carry[WIDTH]^carry[WIDTH-1].
- Latency: accept-to-out_valid is 2+PIPE cycles with no backpressure.
- Throughput: 1 beat/cycle.
- Handshake, per stage: a stage may load when it is empty or its content moves downstream in the same cycle. in_ready = stage0 may load. Combinational out_ready->in_ready path is permitted.
- Holding: out_valid with out_ready=0 holds sum/c_out/ovf stable. out_valid does not drop until the result is accepted.
- Full pipeline plus out_ready=0: in_ready=0. No beat is lost or duplicated, and order is preserved.
- Simultaneous out accept and in accept while full: both occur and occupancy is unchanged.
- Reset mid-operation discards all in-flight beats. First out_valid after release is a beat accepted after release.
- Wrap-around: sum is modulo 2^WIDTH. c_out/ovf carry the information that falls outside it.

Decomposition:
- Shared include/package cla_pkg: GROUP_W default, tree-depth function clog_g(WIDTH,GROUP_W), and a parameter legality check. The check fails elaboration if WIDTH%GROUP_W!=0 or PIPE>1.
- One sub-module, cla_group_n (GROUP_W parameter): inputs P[GROUP_W], G[GROUP_W], cin. Outputs carries[GROUP_W:1], group Pm, group Gm.
- The tree instantiates cla_group_n recursively/generatively. The top level holds only pipeline registers and handshake.

Test Plan (WIDTH=32, PIPE=1 unless stated):
- Add carry chain: a=0xFFFFFFFF, b=0x00000001, c_in=0, sub=0 -> sum=0x00000000, c_out=1, ovf=0, out_valid exactly 3 cycles after accept.
- Subtract: a=5, b=7, sub=1, c_in=1 (ignored) -> sum=0xFFFFFFFE, c_out=0, ovf=0. Then a=7, b=5 -> sum=0x00000002, c_out=1.
- Overflow: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, c_out=0. Also a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
- Backpressure: out_ready=0, in_valid held with 5 distinct beats -> exactly 3 accepted, then in_ready=0. Results stay stable; releasing out_ready drains the results in order, one per cycle.
- Reset mid-flight: assert rst_n low between edges with 2 beats in flight -> out_valid=0 immediately (no clk edge). After release, only new beats appear.
- Random: 10k random a/b/c_in/sub with random out_ready at WIDTH=16 GROUP_W=4 PIPE=0 and WIDTH=64 PIPE=1. Compare against a behavioural +/- model, including c_out and ovf.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int GROUP_W_DEF = 4;

  function automatic int ipow(input int base, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r *= base;
    return r;
  endfunction

  // Levels of GROUP_W-input nodes needed to span width bits.
  function automatic int clog_g(input int width, input int group_w);
    int d    = 0;
    int span = 1;
    while (span < width) begin
      span *= group_w;
      d++;
    end
    return d;
  endfunction

  function automatic bit params_ok(input int width, input int group_w, input int pipe);
    return (group_w >= 2) && (width >= group_w) && ((width % group_w) == 0) &&
           (pipe >= 0) && (pipe <= 1);
  endfunction

endpackage

// File: rtl/cla_group_n.sv
// One lookahead node: every carry is a flat sum of products of the node inputs,
// so nothing ripples inside the node.
module cla_group_n
  import cla_pkg::*;
#(
  parameter int GROUP_W = GROUP_W_DEF
) (
  input  logic [GROUP_W-1:0] p_i,
  input  logic [GROUP_W-1:0] g_i,
  input  logic               cin_i,
  output logic [GROUP_W:1]   carries_o,
  output logic               pm_o,
  output logic               gm_o
);

  function automatic logic lookahead(input logic [GROUP_W-1:0] p, input logic [GROUP_W-1:0] g,
                                     input logic c, input int n);
    logic acc  = 1'b0;
    logic prod = 1'b1;
    for (int j = n - 1; j >= 0; j--) begin
      acc  = acc | (prod & g[j]);
      prod = prod & p[j];
    end
    return acc | (prod & c);
  endfunction

  for (genvar i = 1; i <= GROUP_W; i++) begin : g_carry
    assign carries_o[i] = lookahead(p_i, g_i, cin_i, i);
  end

  // Group P/G are kept independent of cin_i so the tree has no combinational loop.
  assign pm_o = &p_i;
  assign gm_o = lookahead(p_i, g_i, 1'b0, GROUP_W);

endmodule

// File: rtl/cla_tree.sv
// Recursive lookahead tree: GROUP_W subtrees feed one cla_group_n node that returns
// their carry-ins. Widths that are not a power of GROUP_W are zero-padded.
module cla_tree
  import cla_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int GROUP_W = GROUP_W_DEF
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic             cin_i,
  output logic [WIDTH:1]   carry_o,
  output logic             pm_o,
  output logic             gm_o
);

  localparam int DEPTH = clog_g(WIDTH, GROUP_W);
  localparam int NPAD  = ipow(GROUP_W, DEPTH);
  localparam int SUBW  = NPAD / GROUP_W;

  logic [NPAD-1:0] p_pad;
  logic [NPAD-1:0] g_pad;
  logic [NPAD:1]   carry_pad;

  assign p_pad   = NPAD'(p_i);
  assign g_pad   = NPAD'(g_i);
  assign carry_o = carry_pad[WIDTH:1];

  if (NPAD > WIDTH) begin : g_pad_tail
    logic unused_tail;
    assign unused_tail = ^carry_pad[NPAD:WIDTH+1];
  end

  if (DEPTH <= 1) begin : g_leaf
    cla_group_n #(.GROUP_W(GROUP_W)) u_node (
      .p_i      (p_pad),
      .g_i      (g_pad),
      .cin_i    (cin_i),
      .carries_o(carry_pad),
      .pm_o     (pm_o),
      .gm_o     (gm_o)
    );
  end else begin : g_node
    logic [GROUP_W-1:0] sub_pm;
    logic [GROUP_W-1:0] sub_gm;
    logic [GROUP_W-1:0] sub_cin;
    logic [GROUP_W:1]   grp_c;
    logic               unused_grp_cout;

    // The last subtree already produces the carry out of this span.
    assign sub_cin         = {grp_c[GROUP_W-1:1], cin_i};
    assign unused_grp_cout = grp_c[GROUP_W];

    for (genvar k = 0; k < GROUP_W; k++) begin : g_sub
      cla_tree #(.WIDTH(SUBW), .GROUP_W(GROUP_W)) u_sub (
        .p_i    (p_pad[k*SUBW +: SUBW]),
        .g_i    (g_pad[k*SUBW +: SUBW]),
        .cin_i  (sub_cin[k]),
        .carry_o(carry_pad[k*SUBW+1 +: SUBW]),
        .pm_o   (sub_pm[k]),
        .gm_o   (sub_gm[k])
      );
    end

    cla_group_n #(.GROUP_W(GROUP_W)) u_grp (
      .p_i      (sub_pm),
      .g_i      (sub_gm),
      .cin_i    (cin_i),
      .carries_o(grp_c),
      .pm_o     (pm_o),
      .gm_o     (gm_o)
    );
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control:
// input register, optional P/G-tree register, sum/output register.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int GROUP_W = GROUP_W_DEF,
  parameter int PIPE    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  if (!params_ok(WIDTH, GROUP_W, PIPE)) begin : g_bad_params
    $fatal(1, "cla_adder_pipe: WIDTH must be a multiple of GROUP_W (>= GROUP_W) and PIPE 0 or 1");
  end

  logic             s0_valid_q, s0_valid_d, s0_adv;
  logic [WIDTH-1:0] s0_a_q, s0_b_q;
  logic             s0_cin_q;
  logic [WIDTH-1:0] p_w, g_w;
  logic [WIDTH:1]   carry_w;
  logic             unused_pm, unused_gm;
  logic             mid_valid;
  logic [WIDTH-1:0] mid_p;
  logic [WIDTH:0]   mid_c;
  logic             out_valid_q, out_valid_d, out_load;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q, ovf_q;

  // A stage may load when empty or when its content leaves in the same cycle.
  assign out_load = !out_valid_q || out_ready;
  assign in_ready = rst_n && (!s0_valid_q || s0_adv);

  assign p_w = s0_a_q ^ s0_b_q;
  assign g_w = s0_a_q & s0_b_q;

  cla_tree #(.WIDTH(WIDTH), .GROUP_W(GROUP_W)) u_tree (
    .p_i    (p_w),
    .g_i    (g_w),
    .cin_i  (s0_cin_q),
    .carry_o(carry_w),
    .pm_o   (unused_pm),
    .gm_o   (unused_gm)
  );

  if (PIPE == 1) begin : g_pipe
    logic             s1_valid_q, s1_load;
    logic [WIDTH-1:0] s1_p_q;
    logic [WIDTH:0]   s1_c_q;

    assign s1_load = !s1_valid_q || out_load;
    assign s0_adv  = s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       s1_valid_q <= 1'b0;
      else if (s1_load) s1_valid_q <= s0_valid_q;
    end

    always_ff @(posedge clk) begin
      if (s1_load && s0_valid_q) begin
        s1_p_q <= p_w;
        s1_c_q <= {carry_w, s0_cin_q};
      end
    end

    assign mid_valid = s1_valid_q;
    assign mid_p     = s1_p_q;
    assign mid_c     = s1_c_q;
  end else begin : g_comb
    assign s0_adv    = out_load;
    assign mid_valid = s0_valid_q;
    assign mid_p     = p_w;
    assign mid_c     = {carry_w, s0_cin_q};
  end

  always_comb begin
    // NOTE: next-state signals get a default first so no path infers a latch.
    s0_valid_d  = s0_valid_q;
    out_valid_d = out_valid_q;
    if (!s0_valid_q || s0_adv) s0_valid_d = in_valid;
    if (out_load)              out_valid_d = mid_valid;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: datapath registers behind a valid bit need no reset; only the visible outputs are cleared.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s0_a_q   <= a;
      s0_b_q   <= sub ? ~b : b;
      s0_cin_q <= sub | c_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (out_load && mid_valid) begin
      sum_q   <= mid_p ^ mid_c[WIDTH-1:0];
      c_out_q <= mid_c[WIDTH];
      ovf_q   <= mid_c[WIDTH] ^ mid_c[WIDTH-1];
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule
